// File: rtl/less_distance_seq.sv
// ============================================================================
// Module      : less_distance_seq
// Description : Captures a reference, scans COUNT candidates and reports the
//               one nearest the reference with its arrival index and distance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module less_distance_seq #(
    parameter  int W     = 8,
    parameter  int COUNT = 4,
    localparam int IDXW  = $clog2(COUNT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    ref_in,
    input  logic [W-1:0]    data_in,
    input  logic            data_valid,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    nearest,
    output logic [IDXW-1:0] nearest_idx,
    output logic [W-1:0]    min_dist
);

    localparam logic [IDXW-1:0] C_LAST = IDXW'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]    r_ref;
    logic [IDXW-1:0] r_cnt;
    logic [W-1:0]    r_best_val;
    logic [IDXW-1:0] r_best_idx;
    logic [W-1:0]    r_best_dist;
    logic [W-1:0]    r_nearest;
    logic [IDXW-1:0] r_nearest_idx;
    logic [W-1:0]    r_min_dist;

    logic            w_accept;
    logic            w_last;
    logic            w_take;
    logic [W:0]      w_diff;
    logic [W-1:0]    w_dist;

    assign w_accept = (r_state == S_SCAN) && data_valid;
    assign w_last   = (r_cnt == C_LAST);

    // The extra top bit of the difference is the borrow; when set the
    // candidate is below the reference and the low bits are negated.
    assign w_diff = {1'b0, data_in} - {1'b0, r_ref};
    assign w_dist = w_diff[W] ? W'(~w_diff[W-1:0] + 1'b1) : w_diff[W-1:0];

    // Strict less-than keeps the earliest index on ties.
    assign w_take = (r_cnt == '0) || (w_dist < r_best_dist);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref         <= '0;
            r_cnt         <= '0;
            r_best_val    <= '0;
            r_best_idx    <= '0;
            r_best_dist   <= '0;
            r_nearest     <= '0;
            r_nearest_idx <= '0;
            r_min_dist    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_ref <= ref_in;
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_take) begin
                    r_best_val  <= data_in;
                    r_best_idx  <= r_cnt;
                    r_best_dist <= w_dist;
                end
                // Published results change only when the search completes.
                if (w_last) begin
                    r_nearest     <= w_take ? data_in : r_best_val;
                    r_nearest_idx <= w_take ? r_cnt   : r_best_idx;
                    r_min_dist    <= w_take ? w_dist  : r_best_dist;
                end
            end
        end
    end

    assign busy        = (r_state == S_SCAN);
    assign done        = (r_state == S_DONE);
    assign nearest     = r_nearest;
    assign nearest_idx = r_nearest_idx;
    assign min_dist    = r_min_dist;

endmodule

`default_nettype wire

// File: tb/tb_less_distance_seq.sv
// ============================================================================
// Module      : tb_less_distance_seq
// Description : Self-checking bench for less_distance_seq against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_less_distance_seq;

    localparam int W     = 8;
    localparam int COUNT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         data_valid = 1'b0;
    logic [W-1:0] ref_in = '0;
    logic [W-1:0] data_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] nearest;
    logic [1:0]   nearest_idx;
    logic [W-1:0] min_dist;

    int n_checks = 0;
    int n_errors = 0;

    less_distance_seq #(.W(W), .COUNT(COUNT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ref_in      (ref_in),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .busy        (busy),
        .done        (done),
        .nearest     (nearest),
        .nearest_idx (nearest_idx),
        .min_dist    (min_dist)
    );

    always #5 clk = ~clk;

    // Behavioural model: collect candidates in a queue, fold when full.
    bit m_scan = 1'b0;
    bit m_done = 1'b0;
    bit chk_en = 1'b0;
    int m_ref  = 0;
    int cand[$];
    int e_near = 0;
    int e_idx  = 0;
    int e_dist = 0;

    function automatic int absdiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (!rst_n) begin
            m_scan = 1'b0;
            m_done = 1'b0;
            m_ref  = 0;
            cand.delete();
            e_near = 0;
            e_idx  = 0;
            e_dist = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_scan) begin
            if (data_valid) begin
                cand.push_back(int'(data_in));
                if (cand.size() == COUNT) begin
                    int bi;
                    bi = 0;
                    for (int i = 1; i < COUNT; i++)
                        if (absdiff(cand[i], m_ref) < absdiff(cand[bi], m_ref))
                            bi = i;
                    e_near = cand[bi];
                    e_idx  = bi;
                    e_dist = absdiff(cand[bi], m_ref);
                    m_scan = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (start) begin
            m_ref  = int'(ref_in);
            cand.delete();
            m_scan = 1'b1;
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        32'(busy),        32'(m_scan));
            chk("done",        32'(done),        32'(m_done));
            chk("nearest",     32'(nearest),     32'(e_near));
            chk("nearest_idx", 32'(nearest_idx), 32'(e_idx));
            chk("min_dist",    32'(min_dist),    32'(e_dist));
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic do_start(int r);
        start      = 1'b1;
        ref_in     = W'(r);
        data_valid = 1'($urandom % 2);
        data_in    = W'($urandom);
        @(negedge clk);
        start      = 1'b0;
        data_valid = 1'b0;
        ref_in     = W'($urandom);
    endtask

    task automatic send(int v, int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            start      = 1'($urandom % 2);
            data_valid = 1'b0;
            data_in    = W'($urandom);
            @(negedge clk);
        end
        start      = 1'b0;
        data_valid = 1'b1;
        data_in    = W'(v);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic search(int r, int c0, int c1, int c2, int c3, int maxgap,
                          bit lit, int xn, int xi, int xd);
        if (maxgap > 0) begin
            data_valid = 1'b1;
            data_in    = W'($urandom);
            @(negedge clk);
            data_valid = 1'b0;
        end
        do_start(r);
        send(c0, maxgap);
        send(c1, maxgap);
        send(c2, maxgap);
        send(c3, maxgap);
        wait_done();
        if (lit) begin
            chk("lit_nearest",   32'(nearest),     32'(xn));
            chk("lit_idx",       32'(nearest_idx), 32'(xi));
            chk("lit_dist",      32'(min_dist),    32'(xd));
            chk("lit_busy_done", 32'(busy),        32'd0);
            chk("model_nearest", 32'(e_near),      32'(xn));
            chk("model_dist",    32'(e_dist),      32'(xd));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_nearest", 32'(nearest),  32'd0);
        chk("rst_dist",    32'(min_dist), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        search(100,  10,  90, 130, 250, 0, 1'b1,  90, 1, 10);
        search( 50,  40,  60,  45,  55, 0, 1'b1,  45, 2,  5);
        search( 50,  40,  60,  70,  80, 0, 1'b1,  40, 0, 10);
        search(  0, 255, 255, 255, 255, 0, 1'b1, 255, 0, 255);
        search(255,   0,   1, 254,   3, 0, 1'b1, 254, 2,  1);
        search( 20,  30,  18,  25,  19, 3, 1'b1,  19, 3,  1);

        // Abort a search midway with reset.
        do_start(100);
        send(5, 0);
        send(6, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_nearest", 32'(nearest),     32'd0);
        chk("mid_rst_idx",     32'(nearest_idx), 32'd0);
        chk("mid_rst_dist",    32'(min_dist),    32'd0);
        chk("mid_rst_busy",    32'(busy),        32'd0);
        search(7, 7, 0, 0, 0, 1, 1'b1, 7, 0, 0);

        for (int n = 0; n < 50; n++) begin
            search(int'($urandom % 256), int'($urandom % 256), int'($urandom % 256),
                   int'($urandom % 256), int'($urandom % 256), 2, 1'b0, 0, 0, 0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/less_distance_seq.md
Name: less_distance_seq

Overview:
- Sequential, parametrised successor to the two-input less-distance selector.
- Captures a reference value, then accepts a stream of COUNT candidates and reports the candidate closest to the reference, with its index and distance.
- Candidates can arrive on any cycle; the block handles gaps in the stream.
- Used as the nearest-value search stage wherever more than two candidates must be compared against a single reference.

Parameters:
- W, 8, data/reference width in bits (W >= 2)
- COUNT, 4, number of candidates per search (COUNT >= 2)
- IDXW, $clog2(COUNT), width of index output (localparam, derived)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- start  input  1  begin new search; sampled only in IDLE
- ref_in  input  W  reference value, captured on accepted start
- data_in  input  W  candidate value
- data_valid  input  1  data_in is a candidate this cycle; ignored outside SCAN
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse when result is valid
- nearest  output  W  candidate with minimum distance
- nearest_idx  output  IDXW  arrival index (0-based) of nearest
- min_dist  output  W  |nearest - ref|

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - busy, done, nearest, nearest_idx, min_dist and all internal registers = 0.
  - Applies from any state, including mid-SCAN; a partial search is discarded.
- States:
  - IDLE: start=1 -> latch ref_in, cnt=0, go SCAN.
  - SCAN: busy=1. Each cycle with data_valid=1 processes one candidate and increments cnt. The cycle accepting the candidate with cnt==COUNT-1 -> DONE.
  - DONE: done=1 for exactly this one cycle, result outputs are final, busy=0; unconditionally -> IDLE next cycle.
- Distance:
  - Unsigned absolute difference, computed at W+1 bits internally then truncated to W.
  - Result is always <= 2^W-1, so it never wraps.
  - Inputs are unsigned; no signed interpretation.
- Update rule per accepted candidate:
  - First candidate (cnt==0) always loads best.
  - Each later candidate replaces best only if its distance is strictly less than best distance.
  - Ties therefore keep the earliest index.
- Latency: done asserts the cycle after the edge that accepts the last candidate. Minimum total is COUNT+2 cycles from the start edge to the done cycle.
- Outputs:
  - nearest, nearest_idx and min_dist are registers.
  - They update only at the edge entering DONE; the running best is held internally, not on the outputs.
  - They hold their value through IDLE until the next search completes or reset.
- start while in SCAN or DONE is ignored. ref_in changes after capture have no effect.
- data_valid in IDLE or DONE is ignored; no candidate is counted.
- start and data_valid high together in IDLE: only start acts; that data_in is not a candidate.
- Back-to-back: start may be asserted in the IDLE cycle right after DONE.

Test Plan:
- W=8, COUNT=4; reset; start with ref=100; stream 10,90,130,250 on consecutive cycles -> done pulses 1 cycle after 4th valid edge; nearest=90, nearest_idx=1, min_dist=10; busy low in done cycle.
- Tie: ref=50, stream 40,60,45,55 -> nearest=45, idx=2, dist=5. Then ref=50, stream 40,60,70,80 -> nearest=40, idx=0, dist=10 (earliest wins).
- Extremes: ref=0, stream 255,255,255,255 -> nearest=255, idx=0, dist=255. Then ref=255, stream 0,1,254,3 -> nearest=254, idx=2, dist=1.
- Gaps: ref=20, valid pulses with 0-3 idle cycles between candidates 30,18,25,19 -> nearest=19, idx=3, dist=1; busy stays high throughout; done only after 4th valid.
- Reset mid-scan: after 2 of 4 candidates, rst_n=0 for one cycle -> next cycle all outputs 0 and busy=0. New start with ref=7, stream 7,0,0,0 -> nearest=7, idx=0, dist=0.
- Robustness:
  - start pulsed during SCAN, data_valid during IDLE -> no effect on result.
  - 50 random searches compared against a reference model that folds the pairwise less-distance rule in arrival order -> all match.
